// File: rtl/nibble_fifo.sv
// Nibble FIFO feeding the 4-bit register stage; first-word-fall-through, head visible 1 edge after push.
// Backpressure: in_ready = !full; NIBBLE_FIFO_DROP_EN instead keeps in_ready=1 and counts discarded pushes.
module nibble_fifo #(
  parameter int                DATA_W    = 4,
  parameter int                DEPTH     = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(10)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
`ifdef NIBBLE_FIFO_DROP_EN
 ,output logic [7:0]               drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              push, pop;

  // Extra pointer MSB distinguishes a full wrap from empty.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign out_valid = !empty;
  assign count     = count_q;
  assign push      = in_valid && !full;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem_q[rd_ptr_q[AW-1:0]] : hold_q;

`ifdef NIBBLE_FIFO_DROP_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic       drop;

  assign in_ready = 1'b1;
  assign drop     = in_valid && full;
  assign drop_cnt = drop_cnt_q;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= 8'd0;
    else        drop_cnt_q <= drop_cnt_d;
  end
`else
  assign in_ready = !full;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    hold_d   = hold_q;
    if (push) wr_ptr_d = wr_ptr_q + ONE;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ONE;
      hold_d   = mem_q[rd_ptr_q[AW-1:0]];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= RESET_VAL;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
    end
  end

  // Storage is deliberately not reset; reads are gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_nibble_fifo.sv
// Bench for nibble_fifo: queue-based reference model, per-cycle compare, directed and random traffic.
module tb_nibble_fifo;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
`ifdef NIBBLE_FIFO_DROP_EN
  logic [7:0]    drop_cnt;
`endif

  nibble_fifo #(.DATA_W(4), .DEPTH(DEPTH), .RESET_VAL(4'd10)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full), .empty(empty)
`ifdef NIBBLE_FIFO_DROP_EN
   ,.drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue plus the last popped value.
  int q[$];
  int m_hold = 10;
  int m_drops = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_hold  = 10;
      m_drops = 0;
    end else begin
      bit do_pop, do_push;
      do_pop  = (q.size() > 0) && out_ready;
      do_push = in_valid && (q.size() < DEPTH);
      if (in_valid && q.size() == DEPTH && m_drops < 255) m_drops++;
      if (do_pop) m_hold = q.pop_front();
      if (do_push) q.push_back(int'(in_data));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 32'(count), 32'(q.size()));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("out_data", 32'(out_data), 32'((q.size() > 0) ? q[0] : m_hold));
`ifdef NIBBLE_FIFO_DROP_EN
      chk("in_ready", 32'(in_ready), 32'd1);
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
`else
      chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
`endif
    end
  end

  // One cycle: drive at negedge, return 1 time unit after the posedge.
  task automatic cyc(input bit iv, input logic [3:0] id, input bit ordy);
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, 4'd0, 1'b1);
  endtask

  initial begin
    #12;
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_out_data", 32'(out_data), 32'd10);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // 3,5,7 in, then popped on consecutive edges
    cyc(1'b1, 4'd3, 1'b0);
    cyc(1'b1, 4'd5, 1'b0);
    cyc(1'b1, 4'd7, 1'b0);
    chk("burst_count", 32'(count), 32'd3);
    chk("head3", 32'(out_data), 32'd3);
    cyc(1'b0, 4'd0, 1'b1);
    chk("head5", 32'(out_data), 32'd5);
    cyc(1'b0, 4'd0, 1'b1);
    chk("head7", 32'(out_data), 32'd7);
    cyc(1'b0, 4'd0, 1'b1);
    chk("hold7_valid", 32'(out_valid), 32'd0);
    chk("hold7_data", 32'(out_data), 32'd7);

    // fill, refuse while full even with a pop, accept next edge
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 4'(i), 1'b0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd8);
`ifndef NIBBLE_FIFO_DROP_EN
    chk("fill_in_ready", 32'(in_ready), 32'd0);
`endif
    chk("fill_head0", 32'(out_data), 32'd0);
    cyc(1'b1, 4'd9, 1'b1);
    chk("refuse_count", 32'(count), 32'd7);
    chk("refuse_head1", 32'(out_data), 32'd1);
    cyc(1'b1, 4'd9, 1'b0);
    chk("accept9_count", 32'(count), 32'd8);
    drain();
    chk("drain_hold9", 32'(out_data), 32'd9);

    // streaming across pointer wrap
    cyc(1'b1, 4'd0, 1'b1);
    for (int k = 1; k < 16; k++) begin
      chk("stream_head", 32'(out_data), 32'(k - 1));
      cyc(1'b1, 4'(k), 1'b1);
      chk("stream_count", 32'(count), 32'd1);
    end
    cyc(1'b0, 4'd0, 1'b1);
    chk("stream_last", 32'(out_data), 32'd15);

    // async reset between edges with 5 queued
    for (int i = 1; i <= 5; i++) cyc(1'b1, 4'(i), 1'b0);
    chk("pre_rst_count", 32'(count), 32'd5);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_data", 32'(out_data), 32'd10);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_full", 32'(full), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 4'hA, 1'b0);
    chk("post_rst_data", 32'(out_data), 32'hA);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_count", 32'(count), 32'd1);
    drain();

    // random traffic with changing bias
    for (int i = 0; i < 2000; i++) begin
      int pv, pr;
      pv = (i / 250) % 2 == 0 ? 70 : 35;
      pr = (i / 250) % 2 == 0 ? 35 : 70;
      cyc($urandom_range(99) < pv, 4'($urandom), $urandom_range(99) < pr);
    end
    drain();

`ifdef NIBBLE_FIFO_DROP_EN
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 4'(i), 1'b0);
    for (int i = 0; i < 300; i++) cyc(1'b1, 4'($urandom), 1'b0);
    chk("drop_count", 32'(count), 32'd8);
    chk("drop_sat", 32'(drop_cnt), 32'hFF);
    chk("drop_head0", 32'(out_data), 32'd0);
`endif

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
